// File: rtl/joy_dir_arbiter.sv
// Multi-player joystick direction conditioner: sync, debounce, optional rotation, then 4-way/8-way arbitration.
// Optional build macro JOYDIR_SOCD_LAST_EN: 8-way opposite pairs resolve to the most recent press instead of neutral.
module joy_dir_arbiter #(
  parameter int PLAYERS = 2,
  parameter int DEB_LEN = 4,
  parameter int DEB_W   = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic                   mode_8way,
  input  logic                   rotate,
  input  logic [4*PLAYERS-1:0]   dir_in,
  output logic [4*PLAYERS-1:0]   dir_out,
  output logic [PLAYERS-1:0]     changed
);

  // Direction codes are bit indices: 3=up, 2=down, 1=left, 0=right.
  // Recency order packs entry i in bits [2i+1:2i], entry 0 most recent.
  localparam logic [7:0] ORD_RESET = 8'b00_01_10_11;

  function automatic logic [7:0] move_front(input logic [7:0] ord, input logic [1:0] d);
    logic [7:0] res;
    logic       past;
    res = ord;
    for (int i = 1; i < 4; i++) begin
      past = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (ord[2*j +: 2] == d) past = 1'b1;
      end
      if (!past) res[2*i +: 2] = ord[2*(i-1) +: 2];
    end
    res[1:0] = d;
    return res;
  endfunction

  function automatic logic [1:0] rank(input logic [7:0] ord, input logic [1:0] d);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ord[2*i +: 2] == d) r = 2'(i);
    end
    return r;
  endfunction

  logic mode_q, rot_q, cfg_chg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      rot_q  <= 1'b0;
    end else begin
      mode_q <= mode_8way;
      rot_q  <= rotate;
    end
  end

  assign cfg_chg = (mode_8way != mode_q) || (rotate != rot_q);

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0] s1, s2, deb, held, held_prev, prev_eff, new_press;
    logic [3:0] out4, out8, out_next, dir_q;
    logic [7:0] ord, ord_next;
    logic       chg_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        s1 <= 4'd0;
        s2 <= 4'd0;
      end else begin
        s1 <= dir_in[4*p +: 4];
        s2 <= s1;
      end
    end

    if (DEB_LEN == 0) begin : g_nodeb
      assign deb = s2;
    end else begin : g_deb
      localparam logic [DEB_W-1:0] LEN_M1 = DEB_W'(DEB_LEN - 1);
      logic [DEB_W-1:0] cnt [4];

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          deb <= 4'd0;
          for (int b = 0; b < 4; b++) cnt[b] <= '0;
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (s2[b] == deb[b]) begin
              cnt[b] <= '0;
            end else if (ce) begin
              if (cnt[b] == LEN_M1) begin
                deb[b] <= s2[b];
                cnt[b] <= '0;
              end else begin
                cnt[b] <= cnt[b] + 1'b1;
              end
            end
          end
        end
      end
    end

    always_comb begin
      held      = rotate ? {deb[1], deb[0], deb[2], deb[3]} : deb;
      prev_eff  = cfg_chg ? 4'hF : held_prev;
      new_press = held & ~prev_eff;

      // Right applied first, up last, so up ends most recent on a tie.
      ord_next = ord;
      for (int d = 0; d < 4; d++) begin
        if (new_press[d]) ord_next = move_front(ord_next, 2'(d));
      end

      out4 = 4'd0;
      for (int i = 3; i >= 0; i--) begin
        if (held[ord_next[2*i +: 2]]) begin
          out4 = 4'd0;
          out4[ord_next[2*i +: 2]] = 1'b1;
        end
      end

      out8 = held;
`ifdef JOYDIR_SOCD_LAST_EN
      if (held[3] && held[2]) begin
        if (rank(ord_next, 2'd3) < rank(ord_next, 2'd2)) out8[2] = 1'b0;
        else                                             out8[3] = 1'b0;
      end
      if (held[1] && held[0]) begin
        if (rank(ord_next, 2'd1) < rank(ord_next, 2'd0)) out8[0] = 1'b0;
        else                                             out8[1] = 1'b0;
      end
`else
      if (held[3] && held[2]) out8[3:2] = 2'b00;
      if (held[1] && held[0]) out8[1:0] = 2'b00;
`endif

      out_next = mode_8way ? out8 : out4;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        held_prev <= 4'd0;
        ord       <= ORD_RESET;
        dir_q     <= 4'd0;
        chg_q     <= 1'b0;
      end else begin
        held_prev <= held;
        ord       <= ord_next;
        dir_q     <= out_next;
        chg_q     <= (out_next != dir_q);
      end
    end

    assign dir_out[4*p +: 4] = dir_q;
    assign changed[p]        = chg_q;
  end

endmodule

// File: tb/tb_joy_dir_arbiter.sv
// Self-checking bench for joy_dir_arbiter: directed table, hand sequences and a randomized run against a queue-based model.
module tb_joy_dir_arbiter;
  localparam int PLAYERS = 2;
  localparam int DEB_LEN = 4;

  logic                 clk_sys = 1'b0;
  logic                 reset_n;
  logic                 ce;
  logic                 mode_8way;
  logic                 rotate;
  logic [4*PLAYERS-1:0] dir_in;
  logic [4*PLAYERS-1:0] dir_out;
  logic [PLAYERS-1:0]   changed;

  int n_chk  = 0;
  int n_fail = 0;

  joy_dir_arbiter #(.PLAYERS(PLAYERS), .DEB_LEN(DEB_LEN), .DEB_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .mode_8way(mode_8way),
    .rotate(rotate), .dir_in(dir_in), .dir_out(dir_out), .changed(changed)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every player keeps its recency list as a queue of direction codes.
  bit [3:0] m_s1 [PLAYERS];
  bit [3:0] m_s2 [PLAYERS];
  bit [3:0] m_deb[PLAYERS];
  bit [3:0] m_prev[PLAYERS];
  bit [3:0] m_out[PLAYERS];
  bit       m_chg[PLAYERS];
  int       m_cnt[PLAYERS][4];
  int       m_ord[PLAYERS][4];
  bit       m_mode_q, m_rot_q;

  function automatic int qpos(input int q[$], input int d);
    for (int i = 0; i < q.size(); i++) if (q[i] == d) return i;
    return 99;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < PLAYERS; p++) begin
      m_s1[p] = 0; m_s2[p] = 0; m_deb[p] = 0; m_prev[p] = 0; m_out[p] = 0; m_chg[p] = 0;
      for (int b = 0; b < 4; b++) m_cnt[p][b] = 0;
      m_ord[p][0] = 3; m_ord[p][1] = 2; m_ord[p][2] = 1; m_ord[p][3] = 0;
    end
    m_mode_q = 0; m_rot_q = 0;
  endtask

  task automatic model_step();
    bit [3:0] held, newp, o;
    bit       cfg;
    int       q[$];
    cfg = (mode_8way != m_mode_q) || (rotate != m_rot_q);
    for (int p = 0; p < PLAYERS; p++) begin
      held = rotate ? {m_deb[p][1], m_deb[p][0], m_deb[p][2], m_deb[p][3]} : m_deb[p];
      newp = cfg ? 4'd0 : (held & ~m_prev[p]);
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(m_ord[p][i]);
      for (int d = 0; d < 4; d++) begin
        if (newp[d]) begin
          q.delete(qpos(q, d));
          q.push_front(d);
        end
      end
      for (int i = 0; i < 4; i++) m_ord[p][i] = q[i];
      if (!mode_8way) begin
        o = 0;
        for (int i = 0; i < 4; i++) if (o == 0 && held[q[i]]) o = 4'(1 << q[i]);
      end else begin
        o = held;
`ifdef JOYDIR_SOCD_LAST_EN
        if (held[3] && held[2]) o[qpos(q, 3) < qpos(q, 2) ? 2 : 3] = 0;
        if (held[1] && held[0]) o[qpos(q, 1) < qpos(q, 0) ? 0 : 1] = 0;
`else
        if (held[3] && held[2]) begin o[3] = 0; o[2] = 0; end
        if (held[1] && held[0]) begin o[1] = 0; o[0] = 0; end
`endif
      end
      m_chg[p] = (o != m_out[p]);
      m_out[p] = o;
      for (int b = 0; b < 4; b++) begin
        if (m_s2[p][b] == m_deb[p][b]) m_cnt[p][b] = 0;
        else if (ce) begin
          m_cnt[p][b]++;
          if (m_cnt[p][b] == DEB_LEN) begin
            m_deb[p][b] = m_s2[p][b];
            m_cnt[p][b] = 0;
          end
        end
      end
      m_prev[p] = held;
      m_s2[p]   = m_s1[p];
      m_s1[p]   = dir_in[4*p +: 4];
    end
    m_mode_q = mode_8way;
    m_rot_q  = rotate;
  endtask

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk_sys) begin
    for (int p = 0; p < PLAYERS; p++) begin
      check($sformatf("model_dir_p%0d", p), 32'(dir_out[4*p +: 4]), 32'(m_out[p]));
      check($sformatf("model_chg_p%0d", p), 32'(changed[p]), 32'(m_chg[p]));
    end
  end

  typedef struct {
    bit       mode;
    bit [3:0] p0;
    bit [3:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, pulses, cyc;
    vecs[0]  = '{0, 4'b0000, 4'b0000};
    vecs[1]  = '{0, 4'b1000, 4'b1000};
    vecs[2]  = '{0, 4'b1001, 4'b0001};
    vecs[3]  = '{0, 4'b1000, 4'b1000};
    vecs[4]  = '{0, 4'b0000, 4'b0000};
    vecs[5]  = '{0, 4'b1010, 4'b1000};
    vecs[6]  = '{0, 4'b0010, 4'b0010};
    vecs[7]  = '{0, 4'b0000, 4'b0000};
    vecs[8]  = '{1, 4'b1010, 4'b1010};
`ifdef JOYDIR_SOCD_LAST_EN
    vecs[9]  = '{1, 4'b1110, 4'b0110};
`else
    vecs[9]  = '{1, 4'b1110, 4'b0010};
`endif
    vecs[10] = '{1, 4'b0000, 4'b0000};

    reset_n = 0; ce = 1; mode_8way = 0; rotate = 0; dir_in = '0;
    repeat (3) @(negedge clk_sys);
    check("reset_dir", 32'(dir_out), 0);
    check("reset_chg", 32'(changed), 0);
    reset_n = 1;
    repeat (3) @(negedge clk_sys);

    // Latency from raw edge to output, single changed pulse.
    dir_in = 8'h08;
    lat = 0; pulses = 0;
    for (cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk_sys);
      pulses += int'(changed[0]);
      if (lat == 0 && dir_out[3:0] != 0) lat = cyc;
    end
    check("latency", 32'(lat), 7);
    check("up_out", 32'(dir_out[3:0]), 32'b1000);
    check("up_pulses", 32'(pulses), 1);
    check("p1_quiet", 32'(dir_out[7:4]), 0);
    dir_in = 0;
    repeat (10) @(negedge clk_sys);

    // Bounce on left, then stable hold.
    lat = 0; pulses = 0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 1 || cyc == 5) dir_in = 8'h02;
      if (cyc == 3) dir_in = 8'h00;
      @(negedge clk_sys);
      pulses += int'(changed[0]);
      if (lat == 0 && dir_out[3:0] != 0) lat = cyc;
    end
    check("bounce_first_change", 32'(lat), 11);
    check("bounce_out", 32'(dir_out[3:0]), 32'b0010);
    check("bounce_pulses", 32'(pulses), 1);
    dir_in = 0;
    repeat (10) @(negedge clk_sys);

    foreach (vecs[i]) begin
      mode_8way = vecs[i].mode;
      dir_in    = {4'b0000, vecs[i].p0};
      repeat (9) @(negedge clk_sys);
      check($sformatf("vec%0d_p0", i), 32'(dir_out[3:0]), 32'(vecs[i].exp));
      check($sformatf("vec%0d_p1", i), 32'(dir_out[7:4]), 0);
    end

    // Rotation, mode toggle while held, async reset mid-hold.
    mode_8way = 0; rotate = 1; dir_in = 0;
    repeat (4) @(negedge clk_sys);
    dir_in = 8'h02;
    repeat (9) @(negedge clk_sys);
    check("rot_left_to_up", 32'(dir_out[3:0]), 32'b1000);
    mode_8way = 1;
    @(negedge clk_sys);
    check("mode_toggle_out", 32'(dir_out[3:0]), 32'b1000);
    check("mode_toggle_chg", 32'(changed[0]), 0);
    mode_8way = 0;
    repeat (2) @(negedge clk_sys);
    check("mode_back_out", 32'(dir_out[3:0]), 32'b1000);
    #2 reset_n = 0;
    #1 check("async_reset_dir", 32'(dir_out), 0);
    check("async_reset_chg", 32'(changed), 0);
    @(negedge clk_sys);
    reset_n = 1; rotate = 0; dir_in = 0;

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      ce = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) dir_in = 8'($urandom);
      if ($urandom_range(0, 59) == 0) mode_8way = ~mode_8way;
      if ($urandom_range(0, 79) == 0) rotate = ~rotate;
    end
    @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_dir_arbiter.md
Name: joy_dir_arbiter

Overview:
Parametrised multi-player joystick direction conditioner; successor to the single-player 4-way last-pressed mask.
- Per player: synchronises and debounces raw direction bits, applies optional 90° rotation, then arbitrates.
- Arbitration is 4-way with a recency fallback, or 8-way with opposite-direction cleaning.
- Sits between the keyboard/joystick merge logic and the core's in0/in1 input-port packing.

Parameters:
PLAYERS, 2, number of independent players (1..4).
DEB_LEN, 4, consecutive ce samples a raw bit must hold a new value before the debounced bit changes; 0 = debounce bypassed.
DEB_W, 4, width of each debounce counter; DEB_LEN must be < 2**DEB_W.

Ports:
clk_sys  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous active-low reset.
ce  in  1  sample enable for debounce counting (e.g. 1 kHz tick); sync and arbitration run every clk_sys.
mode_8way  in  1  0 = 4-way arbitration, 1 = 8-way.
rotate  in  1  1 = rotate directions 90° for horizontal-screen play.
dir_in  in  4*PLAYERS  raw directions; player p uses bits [4p+3:4p] = {up,down,left,right}.
dir_out  out  4*PLAYERS  conditioned directions, same packing, active-high.
changed  out  PLAYERS  1-cycle pulse when that player's dir_out changes.

Behaviour:
- Reset (async assert, sync release): dir_out=0, changed=0, sync regs=0, debounced=0, counters=0, recency order = {up,down,left,right} (up most recent).
- Sync: two flops per raw bit.
- Debounce, per bit:
  - Sync value equals debounced value: counter cleared.
  - Otherwise, on each ce the counter increments; when it reaches DEB_LEN the debounced value takes the sync value and the counter clears.
  - DEB_LEN=0: debounced = sync value, no ce dependence.
- Rotation, combinational on the debounced bits. rotate=1 maps up<=left, down<=right, left<=down, right<=up. rotate=0 passes through. The result is called held[3:0].
- Press detect: new[d] = held[d] & ~held_prev[d]; held_prev is registered every cycle.
- Recency order: a 4-entry list of 2-bit direction codes, entry 0 most recent.
  - A new press moves that direction to entry 0; the others shift down, relative order preserved.
  - Multiple simultaneous new presses are applied in the order right, left, down, up, so up ends most recent.
- 4-way output: one-hot of the first entry in the order whose held bit is 1, or 0 if none is held.
  - Releasing the winner while another direction is still held falls back to the most recent held direction. It does not go to zero, unlike the predecessor.
- 8-way output: held, with opposite-pair cleaning. up&down both held → both 0; left&right both held → both 0. The other axis is unaffected.
- Mode/rotate change: a change of mode_8way or rotate, detected via registered copies, forces that cycle's held_prev to all-ones. No new-press events occur and the order is kept. dir_out recomputes from the current held bits the next cycle.
- Latency:
  - dir_out is registered, 1 cycle after held changes.
  - Raw edge to dir_out = 2 sync + debounce (DEB_LEN ce ticks) + 1 cycle.
- changed[p] = registered (dir_out_next != dir_out), aligned with the dir_out update.
- Players are fully independent; no shared state.

Optional Feature:
Macro JOYDIR_SOCD_LAST_EN.
- Defined: in 8-way mode, an opposite pair resolves to the more recently pressed of the two, per the recency order, instead of neutral.
- Undefined: an opposite pair resolves to neutral as above.
- 4-way mode is unaffected either way.

Test Plan:
1. PLAYERS=2, DEB_LEN=4, ce every cycle. Reset, then P0 up held. dir_out[3:0]=4'b1000 exactly 2+4+1=7 cycles after the edge; changed[0] pulses once; dir_out[7:4] stays 0.
2. Bounce: P0 left toggled 1,0,1 with 2-cycle spacing, then held. No output change until 4 stable ce samples; a single changed pulse when dir_out=4'b0010.
3. 4-way fallback: hold up, then add right → 4'b0001. Release right → 4'b1000, not 0. Release up → 0.
4. Simultaneous presses: up+left in the same cycle, 4-way → 4'b1000. Release up → 4'b0010.
5. 8-way: up+left → 4'b1010. Add down → 4'b0010 (neutral vertical). With JOYDIR_SOCD_LAST_EN defined → 4'b0110.
6. Rotate: rotate=1, hold raw left → dir_out=4'b1000. Toggle mode_8way while held → no new-press event, order unchanged, output correct next cycle. Assert reset_n=0 mid-hold → dir_out=0 immediately (async).
